// File: rtl/hazard_id_ex_pkg.sv
// Shared pipeline definitions for the ID/EX stage: control-bundle bit positions,
// hazard FSM encoding, and the ID/EX register layout with its bubble value.
package hazard_id_ex_pkg;

   localparam int CTRL_W         = 12;
   localparam int REG_W          = 5;
   localparam int DATA_W         = 32;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_MEMTOREG  = 3;
   localparam int CTRL_ALUSRC    = 4;
   localparam int CTRL_ALUOP_LSB = 5;
   localparam int CTRL_ALUOP_MSB = 8;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hzState_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] dataA;
      logic [DATA_W-1:0] dataB;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
   } idEx_t;

   // All-zero: no control asserted and no destination, so nothing downstream acts on it.
   localparam idEx_t ID_EX_BUBBLE = '0;

   // Register $0 is hardwired, so a write to it never creates a dependency.
   function automatic logic srcMatch(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt);
      return (rd != '0) && ((rd == rs) || (rd == rt));
   endfunction

endpackage

// File: rtl/hazard_id_ex_hazard_detect.sv
// Combinational hazard flags for the instruction in ID against the producers
// currently in EX (ID/EX register) and MEM.
module hazard_detect
   import hazard_id_ex_pkg::*;
(
   input  logic [REG_W-1:0] ifIdRs,
   input  logic [REG_W-1:0] ifIdRt,
   input  logic             branch,
   input  logic             idExRegWrite,
   input  logic             idExMemRead,
   input  logic [REG_W-1:0] idExRd,
   input  logic             exMemMemRead,
   input  logic [REG_W-1:0] exMemRd,
   output logic             loadUse,
   output logic             branch1,
   output logic             branch2
);

   logic exMatch;
   logic memMatch;

   assign exMatch  = srcMatch(idExRd, ifIdRs, ifIdRt);
   assign memMatch = srcMatch(exMemRd, ifIdRs, ifIdRt);

   assign loadUse  = idExMemRead & exMatch;
   // A branch compares in ID, so a load in EX needs two bubbles, an ALU result
   // in EX or a load in MEM needs one.
   assign branch2  = branch & idExMemRead & exMatch;
   assign branch1  = branch & ((idExRegWrite & ~idExMemRead & exMatch) |
                               (exMemMemRead & memMatch));

endmodule

// File: rtl/hazard_id_ex.sv
// ID/EX pipeline register with load-use and branch hazard stalling, flush
// squashing, and a saturating stall-cycle counter.
module hazard_id_ex
   import hazard_id_ex_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  IF_ID_RegRs,
   input  logic [REG_W-1:0]  IF_ID_RegRt,
   input  logic              IDControl_Branch,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_W-1:0]  id_wr_reg,
   input  logic [DATA_W-1:0] id_data_a,
   input  logic [DATA_W-1:0] id_data_b,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              EX_MEM_MemRead,
   input  logic [REG_W-1:0]  EX_MEM_RegRd,
   input  logic              flush,
   output logic [CTRL_W-1:0] ID_EX_Ctrl,
   output logic [REG_W-1:0]  ID_EX_RegRs,
   output logic [REG_W-1:0]  ID_EX_RegRt,
   output logic [REG_W-1:0]  ID_EX_RegRd,
   output logic [DATA_W-1:0] ID_EX_DataA,
   output logic [DATA_W-1:0] ID_EX_DataB,
   output logic [DATA_W-1:0] ID_EX_Imm,
   output logic [DATA_W-1:0] ID_EX_PC,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic [31:0]       stall_count
);

   hzState_t    state, nextState;
   idEx_t       idEx, idIn;
   logic        loadUse, branch1, branch2;
   logic        stall;
   logic [31:0] stallCount;

   hazard_detect u_detect (
      .ifIdRs       (IF_ID_RegRs),
      .ifIdRt       (IF_ID_RegRt),
      .branch       (IDControl_Branch),
      .idExRegWrite (idEx.ctrl[CTRL_REGWRITE]),
      .idExMemRead  (idEx.ctrl[CTRL_MEMREAD]),
      .idExRd       (idEx.rd),
      .exMemMemRead (EX_MEM_MemRead),
      .exMemRd      (EX_MEM_RegRd),
      .loadUse      (loadUse),
      .branch1      (branch1),
      .branch2      (branch2)
   );

   // Flush wins over everything; HOLD ignores hazards and always stalls once.
   always_comb begin
      nextState = state;
      stall     = 1'b0;
      if (flush) begin
         nextState = RUN;
      end else if (state == HOLD) begin
         stall     = 1'b1;
         nextState = RUN;
      end else if (branch2) begin
         stall     = 1'b1;
         nextState = HOLD;
      end else if (loadUse || branch1) begin
         stall     = 1'b1;
      end
   end

   assign PC_Write    = reset | ~stall;
   assign IF_ID_Write = reset | ~stall;

   always_comb begin
      idIn       = ID_EX_BUBBLE;
      idIn.ctrl  = id_ctrl;
      idIn.rs    = IF_ID_RegRs;
      idIn.rt    = IF_ID_RegRt;
      idIn.rd    = id_wr_reg;
      idIn.dataA = id_data_a;
      idIn.dataB = id_data_b;
      idIn.imm   = id_imm;
      idIn.pc    = id_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         idEx       <= ID_EX_BUBBLE;
         stallCount <= '0;
      end else begin
         state <= nextState;
         idEx  <= (flush || stall) ? ID_EX_BUBBLE : idIn;
         if (stall && (stallCount != '1))
            stallCount <= stallCount + 32'd1;
      end
   end

   assign ID_EX_Ctrl  = idEx.ctrl;
   assign ID_EX_RegRs = idEx.rs;
   assign ID_EX_RegRt = idEx.rt;
   assign ID_EX_RegRd = idEx.rd;
   assign ID_EX_DataA = idEx.dataA;
   assign ID_EX_DataB = idEx.dataB;
   assign ID_EX_Imm   = idEx.imm;
   assign ID_EX_PC    = idEx.pc;
   assign stall_count = stallCount;

endmodule

// File: tb/tb_hazard_id_ex.sv
// Directed-vector bench for hazard_id_ex: stall/bubble behaviour, flush, reset.
module tb_hazard_id_ex;

   localparam logic [11:0] C_LW  = 12'h01B;  // RegWrite|MemRead|MemToReg|ALUSrc
   localparam logic [11:0] C_ADD = 12'h041;  // RegWrite, ALUOp=2
   localparam logic [11:0] C_BEQ = 12'h020;  // ALUOp=1

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  IF_ID_RegRs, IF_ID_RegRt;
   logic        IDControl_Branch;
   logic [11:0] id_ctrl;
   logic [4:0]  id_wr_reg;
   logic [31:0] id_data_a, id_data_b, id_imm, id_pc;
   logic        EX_MEM_MemRead;
   logic [4:0]  EX_MEM_RegRd;
   logic        flush;
   logic [11:0] ID_EX_Ctrl;
   logic [4:0]  ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd;
   logic [31:0] ID_EX_DataA, ID_EX_DataB, ID_EX_Imm, ID_EX_PC;
   logic        PC_Write, IF_ID_Write;
   logic [31:0] stall_count;

   int nTests = 0;
   int nFail  = 0;

   hazard_id_ex dut (
      .clk(clk), .reset(reset),
      .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
      .IDControl_Branch(IDControl_Branch), .id_ctrl(id_ctrl),
      .id_wr_reg(id_wr_reg), .id_data_a(id_data_a), .id_data_b(id_data_b),
      .id_imm(id_imm), .id_pc(id_pc),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_RegRd(EX_MEM_RegRd),
      .flush(flush),
      .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt),
      .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_DataA(ID_EX_DataA), .ID_EX_DataB(ID_EX_DataB),
      .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
      .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after a rising edge; checks run after another unit.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic setId(input logic [11:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] wr, input logic br);
      id_ctrl = ctrl; IF_ID_RegRs = rs; IF_ID_RegRt = rt; id_wr_reg = wr;
      IDControl_Branch = br;
      id_data_a = {27'h0, rs} + 32'h1000;
      id_data_b = {27'h0, rt} + 32'h2000;
      id_imm    = {27'h0, wr} + 32'h3000;
      id_pc     = id_pc + 32'd4;
   endtask

   task automatic clearIn();
      reset = 1'b0; flush = 1'b0; EX_MEM_MemRead = 1'b0; EX_MEM_RegRd = 5'd0;
      id_pc = 32'h0000_0400;
      setId(12'h0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   task automatic doReset();
      clearIn();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Push one producer into ID/EX (ID/EX is a bubble beforehand, so no stall).
   task automatic issue(input logic [11:0] ctrl, input logic [4:0] wr);
      setId(ctrl, 5'd1, 5'd2, wr, 1'b0);
      tick();
   endtask

   task automatic test_reset();
      clearIn();
      reset = 1'b1; flush = 1'b1; IDControl_Branch = 1'b1;
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd3; IF_ID_RegRs = 5'd3;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1) begin
         nFail++; $display("FAIL reset_write: got PC_Write=%b IF_ID_Write=%b, want 1/1", PC_Write, IF_ID_Write);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== 12'h0 || ID_EX_RegRd !== 5'd0 || ID_EX_RegRs !== 5'd0 || ID_EX_DataA !== 32'h0 ||
          ID_EX_PC !== 32'h0 || stall_count !== 32'h0) begin
         nFail++; $display("FAIL reset_state: ctrl=%h rd=%0d rs=%0d dataA=%h pc=%h cnt=%0d, want all 0",
                           ID_EX_Ctrl, ID_EX_RegRd, ID_EX_RegRs, ID_EX_DataA, ID_EX_PC, stall_count);
      end
   endtask

   task automatic test_passthrough();
      doReset();
      id_ctrl = 12'hA5C; IF_ID_RegRs = 5'd17; IF_ID_RegRt = 5'd22; id_wr_reg = 5'd31;
      id_data_a = 32'hDEAD_BEEF; id_data_b = 32'h1234_5678; id_imm = 32'hFFFF_FF80; id_pc = 32'h0040_0010;
      settle();
      nTests++;
      if (PC_Write !== 1'b1) begin
         nFail++; $display("FAIL pass_pcwrite: got %b want 1", PC_Write);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== 12'hA5C || ID_EX_RegRs !== 5'd17 || ID_EX_RegRt !== 5'd22 || ID_EX_RegRd !== 5'd31 ||
          ID_EX_DataA !== 32'hDEAD_BEEF || ID_EX_DataB !== 32'h1234_5678 || ID_EX_Imm !== 32'hFFFF_FF80 ||
          ID_EX_PC !== 32'h0040_0010) begin
         nFail++; $display("FAIL pass_fields: ctrl=%h rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h pc=%h", ID_EX_Ctrl,
                           ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_DataA, ID_EX_DataB, ID_EX_Imm, ID_EX_PC);
      end
      // Back-to-back: next instruction lands one cycle later, no stall.
      setId(C_ADD, 5'd4, 5'd5, 5'd6, 1'b0);
      tick();
      nTests++;
      if (ID_EX_Ctrl !== C_ADD || ID_EX_RegRd !== 5'd6 || ID_EX_DataA !== 32'h1004 || stall_count !== 32'd0) begin
         nFail++; $display("FAIL back_to_back: ctrl=%h rd=%0d a=%h cnt=%0d, want %h 6 1004 0",
                           ID_EX_Ctrl, ID_EX_RegRd, ID_EX_DataA, stall_count, C_ADD);
      end
   endtask

   task automatic test_load_use();
      doReset();
      issue(C_LW, 5'd8);
      setId(C_ADD, 5'd8, 5'd2, 5'd3, 1'b0);  // add $3,$8,$2
      settle();
      nTests++;
      if (PC_Write !== 1'b0 || IF_ID_Write !== 1'b0) begin
         nFail++; $display("FAIL lu_stall: got PC_Write=%b IF_ID_Write=%b, want 0/0", PC_Write, IF_ID_Write);
      end
      tick();
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd8;
      settle();
      nTests++;
      if (ID_EX_Ctrl !== 12'h0 || ID_EX_RegRd !== 5'd0 || stall_count !== 32'd1 || PC_Write !== 1'b1) begin
         nFail++; $display("FAIL lu_bubble: ctrl=%h rd=%0d cnt=%0d pcw=%b, want 0 0 1 1",
                           ID_EX_Ctrl, ID_EX_RegRd, stall_count, PC_Write);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== C_ADD || ID_EX_RegRs !== 5'd8 || ID_EX_RegRd !== 5'd3 || stall_count !== 32'd1) begin
         nFail++; $display("FAIL lu_issue: ctrl=%h rs=%0d rd=%0d cnt=%0d, want %h 8 3 1",
                           ID_EX_Ctrl, ID_EX_RegRs, ID_EX_RegRd, stall_count, C_ADD);
      end
   endtask

   task automatic test_branch_after_load();
      doReset();
      issue(C_LW, 5'd9);
      setId(C_BEQ, 5'd9, 5'd2, 5'd0, 1'b1);  // beq $9,$2
      settle();
      nTests++;
      if (PC_Write !== 1'b0) begin
         nFail++; $display("FAIL bl_stall1: got PC_Write=%b want 0", PC_Write);
      end
      tick();
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd9;
      settle();
      nTests++;
      if (PC_Write !== 1'b0 || IF_ID_Write !== 1'b0 || ID_EX_Ctrl !== 12'h0 || stall_count !== 32'd1) begin
         nFail++; $display("FAIL bl_hold: pcw=%b ifw=%b ctrl=%h cnt=%0d, want 0 0 0 1",
                           PC_Write, IF_ID_Write, ID_EX_Ctrl, stall_count);
      end
      tick();
      EX_MEM_MemRead = 1'b0; EX_MEM_RegRd = 5'd0;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || ID_EX_Ctrl !== 12'h0 || stall_count !== 32'd2) begin
         nFail++; $display("FAIL bl_resolve: pcw=%b ctrl=%h cnt=%0d, want 1 0 2", PC_Write, ID_EX_Ctrl, stall_count);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== C_BEQ || ID_EX_RegRs !== 5'd9 || stall_count !== 32'd2) begin
         nFail++; $display("FAIL bl_issue: ctrl=%h rs=%0d cnt=%0d, want %h 9 2", ID_EX_Ctrl, ID_EX_RegRs, stall_count, C_BEQ);
      end
   endtask

   task automatic test_branch_after_alu();
      doReset();
      issue(C_ADD, 5'd10);
      setId(C_BEQ, 5'd1, 5'd10, 5'd0, 1'b1);  // beq $1,$10
      settle();
      nTests++;
      if (PC_Write !== 1'b0) begin
         nFail++; $display("FAIL ba_stall: got PC_Write=%b want 0", PC_Write);
      end
      tick();
      EX_MEM_MemRead = 1'b0; EX_MEM_RegRd = 5'd10;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || ID_EX_Ctrl !== 12'h0 || stall_count !== 32'd1) begin
         nFail++; $display("FAIL ba_release: pcw=%b ctrl=%h cnt=%0d, want 1 0 1", PC_Write, ID_EX_Ctrl, stall_count);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== C_BEQ || ID_EX_RegRt !== 5'd10 || stall_count !== 32'd1) begin
         nFail++; $display("FAIL ba_issue: ctrl=%h rt=%0d cnt=%0d, want %h 10 1", ID_EX_Ctrl, ID_EX_RegRt, stall_count, C_BEQ);
      end
   endtask

   task automatic test_branch_mem_load();
      doReset();
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd7;
      setId(C_BEQ, 5'd7, 5'd3, 5'd0, 1'b1);
      settle();
      nTests++;
      if (PC_Write !== 1'b0) begin
         nFail++; $display("FAIL bm_stall: got PC_Write=%b want 0", PC_Write);
      end
      tick();
      EX_MEM_MemRead = 1'b0; EX_MEM_RegRd = 5'd0;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || stall_count !== 32'd1) begin
         nFail++; $display("FAIL bm_release: pcw=%b cnt=%0d, want 1 1", PC_Write, stall_count);
      end
   endtask

   task automatic test_reg_zero();
      doReset();
      issue(C_LW, 5'd0);
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd0;
      setId(C_BEQ, 5'd0, 5'd0, 5'd0, 1'b1);
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1) begin
         nFail++; $display("FAIL zero_branch: pcw=%b ifw=%b, want 1 1", PC_Write, IF_ID_Write);
      end
      tick();
      setId(C_ADD, 5'd0, 5'd0, 5'd5, 1'b0);
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || ID_EX_Ctrl !== C_BEQ || stall_count !== 32'd0) begin
         nFail++; $display("FAIL zero_issue: pcw=%b ctrl=%h cnt=%0d, want 1 %h 0", PC_Write, ID_EX_Ctrl, stall_count, C_BEQ);
      end
   endtask

   task automatic test_flush_hazard();
      doReset();
      issue(C_LW, 5'd9);
      setId(C_BEQ, 5'd9, 5'd2, 5'd0, 1'b1);
      flush = 1'b1;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1) begin
         nFail++; $display("FAIL flush_write: pcw=%b ifw=%b, want 1 1", PC_Write, IF_ID_Write);
      end
      tick();
      flush = 1'b0;
      EX_MEM_MemRead = 1'b1; EX_MEM_RegRd = 5'd9;
      setId(C_ADD, 5'd4, 5'd5, 5'd6, 1'b0);
      settle();
      nTests++;
      if (ID_EX_Ctrl !== 12'h0 || ID_EX_RegRd !== 5'd0 || ID_EX_DataA !== 32'h0 || stall_count !== 32'd0 ||
          PC_Write !== 1'b1) begin
         nFail++; $display("FAIL flush_bubble: ctrl=%h rd=%0d a=%h cnt=%0d pcw=%b, want 0 0 0 0 1",
                           ID_EX_Ctrl, ID_EX_RegRd, ID_EX_DataA, stall_count, PC_Write);
      end
      tick();
      nTests++;
      if (ID_EX_Ctrl !== C_ADD || ID_EX_RegRd !== 5'd6 || stall_count !== 32'd0) begin
         nFail++; $display("FAIL flush_next: ctrl=%h rd=%0d cnt=%0d, want %h 6 0", ID_EX_Ctrl, ID_EX_RegRd, stall_count, C_ADD);
      end
   endtask

   task automatic test_reset_mid_hold();
      doReset();
      issue(C_LW, 5'd9);
      setId(C_BEQ, 5'd9, 5'd2, 5'd0, 1'b1);
      tick();
      nTests++;
      if (stall_count !== 32'd1 || PC_Write !== 1'b0) begin
         nFail++; $display("FAIL rh_inhold: cnt=%0d pcw=%b, want 1 0", stall_count, PC_Write);
      end
      reset = 1'b1;
      settle();
      nTests++;
      if (PC_Write !== 1'b1 || IF_ID_Write !== 1'b1) begin
         nFail++; $display("FAIL rh_write: pcw=%b ifw=%b, want 1 1", PC_Write, IF_ID_Write);
      end
      tick();
      reset = 1'b0;
      settle();
      nTests++;
      if (ID_EX_Ctrl !== 12'h0 || stall_count !== 32'd0 || PC_Write !== 1'b1) begin
         nFail++; $display("FAIL rh_after: ctrl=%h cnt=%0d pcw=%b, want 0 0 1", ID_EX_Ctrl, stall_count, PC_Write);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_use();
      test_branch_after_load();
      test_branch_after_alu();
      test_branch_mem_load();
      test_reg_zero();
      test_flush_hazard();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_id_ex.md
HAZARD_ID_EX -- requirements
Module: hazard_id_ex

Interface
REQ-001 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have IF_ID_RegRs and IF_ID_RegRt, inputs, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have IDControl_Branch, input, 1 bit: the instruction in ID is a branch that is resolved in ID.
REQ-005 SHALL have id_ctrl, input, 12 bits: ID control bundle, with [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemToReg, [4] ALUSrc, [8:5] ALUOp, [11:9] spare.
REQ-006 SHALL have id_wr_reg (input, 5 bits: resolved destination register), id_data_a, id_data_b, id_imm and id_pc (inputs, 32 bits each).
REQ-007 SHALL have EX_MEM_MemRead (input, 1 bit) and EX_MEM_RegRd (input, 5 bits): load status and destination of the instruction in MEM.
REQ-008 SHALL have flush, input, 1 bit: taken branch/jump; the ID instruction is squashed.
REQ-009 SHALL have outputs ID_EX_Ctrl (12 bits), ID_EX_RegRs, ID_EX_RegRt and ID_EX_RegRd (5 bits each), and ID_EX_DataA, ID_EX_DataB, ID_EX_Imm and ID_EX_PC (32 bits each), all registered.
REQ-010 SHALL have outputs PC_Write and IF_ID_Write, 1 bit each, combinational: 0 means hold the register.
REQ-011 SHALL have stall_count, output, 32 bits, registered: count of stall cycles, saturating.

Function
REQ-012 SHALL define a load-use hazard as: ID_EX_Ctrl[1], ID_EX_RegRd != 0, and ID_EX_RegRd equal to IF_ID_RegRs or IF_ID_RegRt.
REQ-013 SHALL define a 2-cycle branch hazard as: IDControl_Branch, ID_EX_Ctrl[1], ID_EX_RegRd != 0, and ID_EX_RegRd matching IF_ID_RegRs or IF_ID_RegRt.
REQ-014 SHALL define a 1-cycle branch hazard as either of:
- IDControl_Branch, ID_EX_Ctrl[0] with ID_EX_Ctrl[1]=0, ID_EX_RegRd != 0, and a source match;
- IDControl_Branch, EX_MEM_MemRead, EX_MEM_RegRd != 0, and a source match.
REQ-015 SHALL implement FSM states RUN and HOLD.
- Hazards are evaluated only in RUN.
- HOLD forces a stall unconditionally for exactly one cycle, then returns to RUN.
REQ-016 SHALL, in RUN, handle hazards as follows:
- 2-cycle branch hazard: stall this cycle, next state HOLD.
- Load-use hazard or 1-cycle branch hazard: stall this cycle, stay in RUN (re-evaluate next cycle).
- No hazard: PC_Write = 1, IF_ID_Write = 1.
REQ-017 SHALL, on a stall cycle, set PC_Write = 0 and IF_ID_Write = 0, and load a bubble into ID/EX at the edge.
REQ-018 SHALL define a bubble as ID_EX_Ctrl = 0 and ID_EX_RegRd = 0, with all other ID/EX fields don't-care but deterministic (zero).
REQ-019 SHALL, on a non-stall cycle, load every id_* field plus IF_ID_RegRs and IF_ID_RegRt into ID/EX at the edge.
REQ-020 SHALL give flush the highest priority: bubble loaded, next state RUN, and PC_Write/IF_ID_Write driven to 1 regardless of any hazard.
REQ-021 SHALL increment stall_count on every stall cycle, excluding flush cycles, and hold it at 0xFFFFFFFF once reached.
REQ-022 SHALL insert exactly one cycle of ID/EX latency from ID input to ID/EX output.
REQ-023 SHALL ignore destination register 0 in all hazard checks.

Reset
REQ-024 SHALL, on reset at a rising edge, set the FSM to RUN, all ID/EX outputs to 0 (a bubble), and stall_count to 0.
REQ-025 SHALL drive PC_Write = 1 and IF_ID_Write = 1 while reset is high.
REQ-026 SHALL let reset override flush and any HOLD in progress.

Structure
REQ-027 SHALL place the id_ctrl bit-index constants, the FSM state encoding and the bubble value in a shared pipeline package.
REQ-028 SHALL contain one sub-module, hazard_detect: combinational, producing the load-use, 1-cycle and 2-cycle hazard flags.

Verification
REQ-029 SHALL check load-use: lw $8 sits in ID/EX and add uses $8 in ID -> one stall cycle, bubble in ID/EX, add issues on the next cycle, stall_count = 1.
REQ-030 SHALL check branch after load: lw $9 sits in ID/EX and beq uses $9 -> two stall cycles (RUN then HOLD), beq resolves in the 3rd cycle, stall_count = 2.
REQ-031 SHALL check branch after ALU: add $10 sits in ID/EX and beq uses $10 -> exactly one stall cycle.
REQ-032 SHALL check register $0: lw $0 in ID/EX and a consumer of $0 -> no stall, PC_Write = 1 throughout.
REQ-033 SHALL check flush during hazard: flush = 1 in the same cycle as a 2-cycle branch hazard -> bubble loaded, next state RUN, no HOLD cycle, stall_count unchanged.
REQ-034 SHALL check reset mid-HOLD: reset asserted in HOLD -> next cycle in RUN, ID_EX_Ctrl = 0, stall_count = 0.
